// File: rtl/fetch_if_id_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if_id_if
// Description : Signal bundle between the fetch stage and its neighbours:
//               decode/EX control inputs (stall, branch redirect, halt),
//               the instruction-memory read port and the IF/ID register
//               outputs.
//   master : fetch stage side (drives imem_rd/imem_addr and IF/ID outputs)
//   slave  : environment side (memory, decode, EX)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if_id_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_id;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready;
  logic [15:0] instr_id;
  logic [15:0] pc_plus2_id;
  logic        valid_id;
  logic        halted;

  modport master (
    input  stall, branch_taken, branch_target, halt_id, imem_data, imem_ready,
    output imem_rd, imem_addr, instr_id, pc_plus2_id, valid_id, halted
  );

  modport slave (
    output stall, branch_taken, branch_target, halt_id, imem_data, imem_ready,
    input  imem_rd, imem_addr, instr_id, pc_plus2_id, valid_id, halted
  );
endinterface
`default_nettype wire

// File: rtl/fetch_if_id.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if_id
// Description : Instruction fetch stage plus IF/ID pipeline register.
//               Owns the PC, drives a variable-latency instruction memory and
//               presents fetched instructions to decode. Handles decode
//               stalls, EX branch redirects (draining a wrong-path request if
//               one is in flight) and HALT, inserting NOP bubbles as needed.
// Ports       : clk   - system clock, rising edge
//               rst_n - synchronous active-low reset
//               bus   - fetch_if_id_if.master (control inputs, imem port,
//                       IF/ID outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_if_id #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  fetch_if_id_if.master  bus
);

  localparam logic [1:0] S_FETCH         = 2'd0;
  localparam logic [1:0] S_WAIT          = 2'd1;
  localparam logic [1:0] S_REDIRECT_WAIT = 2'd2;
  localparam logic [1:0] S_HALTED        = 2'd3;

  localparam logic [15:0] c_pc_step = 16'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pc_plus2;
  logic        r_valid;
  logic        r_halted;

  logic        w_imem_rd;
  logic        w_take_branch;
  logic        w_set_halt;
  logic        w_accept;
  logic        w_bubble;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic; priority branch > stall > halt > normal
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH, S_WAIT: begin
        if (bus.branch_taken)
          // A request still outstanding on the old path must be drained.
          w_state_next = bus.imem_ready ? S_FETCH : S_REDIRECT_WAIT;
        else if (bus.stall)
          w_state_next = r_state;
        else if (bus.halt_id)
          w_state_next = S_HALTED;
        else
          w_state_next = bus.imem_ready ? S_FETCH : S_WAIT;
      end
      S_REDIRECT_WAIT: begin
        if (bus.branch_taken || bus.stall)
          w_state_next = S_REDIRECT_WAIT;
        else if (bus.halt_id)
          w_state_next = S_HALTED;
        else if (bus.imem_ready)
          w_state_next = S_FETCH;
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath-control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_imem_rd     = rst_n && (r_state != S_HALTED);
    w_take_branch = 1'b0;
    w_set_halt    = 1'b0;
    w_accept      = 1'b0;
    w_bubble      = 1'b0;
    if (r_state != S_HALTED) begin
      if (bus.branch_taken) begin
        w_take_branch = 1'b1;
        w_bubble      = 1'b1;
      end else if (!bus.stall) begin
        if (bus.halt_id) begin
          w_set_halt = 1'b1;
          w_bubble   = 1'b1;
        end else if (r_state != S_REDIRECT_WAIT && bus.imem_ready) begin
          w_accept = 1'b1;
        end else begin
          // Waiting on memory or draining a wrong-path read.
          w_bubble = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC and IF/ID register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= 16'h0000;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (w_take_branch)
        r_pc <= bus.branch_target;
      else if (w_accept)
        r_pc <= r_pc + c_pc_step;

      if (w_accept) begin
        r_instr    <= bus.imem_data;
        r_pc_plus2 <= r_pc + c_pc_step;
        r_valid    <= 1'b1;
      end else if (w_bubble) begin
        // pc_plus2_id is left untouched by a bubble.
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end

      if (w_set_halt)
        r_halted <= 1'b1;
    end
  end

  assign bus.imem_rd     = w_imem_rd;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_id    = r_instr;
  assign bus.pc_plus2_id = r_pc_plus2;
  assign bus.valid_id    = r_valid;
  assign bus.halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_if_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_if_id
// Description : Self-checking bench for fetch_if_id. Memory returns
//               addr ^ 16'hA5A5; a behavioural model tracks the PC, IF/ID
//               contents, a "draining wrong-path read" flag and the halt flag,
//               and is compared against the DUT on every falling edge.
//               Directed scenarios pin literal values; a randomized phase
//               follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_if_id;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] c_key     = 16'hA5A5;

  logic clk = 1'b0;
  logic rst_n;

  fetch_if_id_if bus ();

  fetch_if_id #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = bus.imem_addr ^ c_key;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid, m_halted, m_drain;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_drain = 1'b0; m_live = 1'b1;
    end else if (m_live && !m_halted) begin
      if (bus.branch_taken) begin
        m_drain = m_drain || !bus.imem_ready;
        m_pc = bus.branch_target;
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (bus.stall) begin
        // everything frozen
      end else if (bus.halt_id) begin
        m_halted = 1'b1;
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (m_drain) begin
        if (bus.imem_ready) m_drain = 1'b0;
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (bus.imem_ready) begin
        m_instr = m_pc ^ c_key;
        m_pc2   = m_pc + 16'd2;
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd2;
      end else begin
        m_instr = NOP_INSTR; m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("instr_id",    bus.instr_id,          m_instr);
      chk("pc_plus2_id", bus.pc_plus2_id,       m_pc2);
      chk("valid_id",    16'(bus.valid_id),     16'(m_valid));
      chk("halted",      16'(bus.halted),       16'(m_halted));
      chk("imem_addr",   bus.imem_addr,         m_pc);
      chk("imem_rd",     16'(bus.imem_rd),      16'(rst_n && !m_halted));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input logic rn, input logic rdy, input logic st,
                     input logic br, input logic [15:0] tgt, input logic hl);
    rst_n             = rn;
    bus.imem_ready    = rdy;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt_id       = hl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bus.imem_ready = 1'b0; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 16'h0000; bus.halt_id = 1'b0;

    // Reset values
    cyc(0, 0, 0, 0, 16'h0, 0);
    cyc(0, 1, 1, 1, 16'h1234, 1);
    chk("rst_instr", bus.instr_id, 16'h0800);
    chk("rst_pc2",   bus.pc_plus2_id, 16'h0000);
    chk("rst_valid", 16'(bus.valid_id), 16'h0);
    chk("rst_halted",16'(bus.halted), 16'h0);
    chk("rst_addr",  bus.imem_addr, 16'h0000);
    chk("rst_rd",    16'(bus.imem_rd), 16'h0);

    // Zero-wait streaming
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("rd_on", 16'(bus.imem_rd), 16'h1);
    chk("s0_instr", bus.instr_id, 16'hA5A5); chk("s0_pc2", bus.pc_plus2_id, 16'h0002);
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("s1_instr", bus.instr_id, 16'hA5A7); chk("s1_pc2", bus.pc_plus2_id, 16'h0004);
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("s2_instr", bus.instr_id, 16'hA5A1); chk("s2_pc2", bus.pc_plus2_id, 16'h0006);
    chk("s2_valid", 16'(bus.valid_id), 16'h1);

    // Memory busy three cycles at pc=6
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 16'h0, 0);
      chk("wait_valid", 16'(bus.valid_id), 16'h0);
      chk("wait_addr", bus.imem_addr, 16'h0006);
    end
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("w_instr", bus.instr_id, 16'hA5A3); chk("w_addr", bus.imem_addr, 16'h0008);

    // Stall two cycles at pc=8
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 0, 16'h0, 0);
      chk("stall_instr", bus.instr_id, 16'hA5A3);
      chk("stall_pc2", bus.pc_plus2_id, 16'h0008);
      chk("stall_addr", bus.imem_addr, 16'h0008);
    end
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("post_stall_instr", bus.instr_id, 16'hA5AD);
    chk("post_stall_pc2", bus.pc_plus2_id, 16'h000A);

    // Branch with stall while waiting -> drain wrong-path read
    cyc(1, 0, 0, 0, 16'h0, 0);
    cyc(1, 0, 1, 1, 16'h0040, 0);
    chk("br_addr", bus.imem_addr, 16'h0040); chk("br_valid", 16'(bus.valid_id), 16'h0);
    cyc(1, 0, 0, 0, 16'h0, 0);
    chk("drain_valid0", 16'(bus.valid_id), 16'h0);
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("drain_valid1", 16'(bus.valid_id), 16'h0);
    chk("drain_instr", bus.instr_id, 16'h0800);
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("tgt_instr", bus.instr_id, 16'hA5E5); chk("tgt_pc2", bus.pc_plus2_id, 16'h0042);

    // Branch beats halt, then halt alone
    cyc(1, 1, 0, 1, 16'h0100, 1);
    chk("brhalt_halted", 16'(bus.halted), 16'h0); chk("brhalt_addr", bus.imem_addr, 16'h0100);
    cyc(1, 1, 0, 0, 16'h0, 1);
    chk("halt_halted", 16'(bus.halted), 16'h1); chk("halt_rd", 16'(bus.imem_rd), 16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
      chk("halted_hold", 16'(bus.halted), 16'h1);
      chk("halted_valid", 16'(bus.valid_id), 16'h0);
      chk("halted_addr", bus.imem_addr, 16'h0100);
    end
    cyc(0, 0, 0, 0, 16'h0, 0);
    chk("rr_halted", 16'(bus.halted), 16'h0); chk("rr_addr", bus.imem_addr, 16'h0000);
    chk("rr_instr", bus.instr_id, 16'h0800);
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("rr_first", bus.instr_id, 16'hA5A5);

    // PC wrap
    cyc(1, 1, 0, 1, 16'hFFFE, 0);
    chk("wrap_addr0", bus.imem_addr, 16'hFFFE);
    cyc(1, 1, 0, 0, 16'h0, 0);
    chk("wrap_instr", bus.instr_id, 16'h5A5B);
    chk("wrap_pc2", bus.pc_plus2_id, 16'h0000);
    chk("wrap_addr1", bus.imem_addr, 16'h0000);
    chk("model_wrap", m_pc2, 16'h0000);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic rn, rdy, st, br, hl;
      rn  = ($urandom_range(99) >= 2);
      rdy = ($urandom_range(99) < 60);
      st  = ($urandom_range(99) < 25);
      br  = ($urandom_range(99) < 8);
      hl  = ($urandom_range(99) < 2);
      cyc(rn, rdy, st, br, 16'($urandom), hl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
